// File: rtl/rr_dispatch_pkg.sv
// Shared constants and helpers for the round-robin dispatcher/arbiter family.
// Purely declarative; no timing or flow control of its own.
package rr_dispatch_pkg;

    localparam int DEF_NUM_DST = 10;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_CREDITS = 4;
    localparam int OH_MAX      = 64;

    function automatic int cnt_w(input int credits);
        return $clog2(credits + 1);
    endfunction

    // Index of the set bit; callers guarantee at most one bit is set.
    function automatic int unsigned oh2idx(input logic [OH_MAX-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < OH_MAX; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_dispatcher_if.sv
// Dispatcher bus: input stream, one-hot registered output and credit return.
// master = dispatcher side, slave = source/destination side.
interface rr_dispatcher_if #(
    parameter int NUM_DST = rr_dispatch_pkg::DEF_NUM_DST,
    parameter int DATA_W  = rr_dispatch_pkg::DEF_DATA_W
);
    localparam int IDX_W = $clog2(NUM_DST);

    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_data;
    logic [NUM_DST-1:0]  out_valid;
    logic [IDX_W-1:0]    out_dst;
    logic [DATA_W-1:0]   out_data;
    logic [NUM_DST-1:0]  credit_ret;
    logic [NUM_DST-1:0]  credit_avail;
    logic                credit_err;

    modport master (
        input  in_valid, in_data, credit_ret,
        output in_ready, out_valid, out_dst, out_data, credit_avail, credit_err
    );

    modport slave (
        output in_valid, in_data, credit_ret,
        input  in_ready, out_valid, out_dst, out_data, credit_avail, credit_err
    );
endinterface

// File: rtl/rr_dispatcher_pick.sv
// Rotating-priority picker: first eligible bit at or above start, wrapping.
// Combinational, zero latency; no flow control.
module rr_pick
    import rr_dispatch_pkg::*;
#(
    parameter int N = DEF_NUM_DST
) (
    input  logic [N-1:0]         elig,
    input  logic [$clog2(N)-1:0] start,
    output logic [N-1:0]         pick_oh,
    output logic [$clog2(N)-1:0] pick_idx,
    output logic                 any
);
    localparam int IW = $clog2(N);

    logic [N-1:0] rot;
    logic [N-1:0] rot_oh;

    // Rotate so start lands at bit 0, take lowest set bit, rotate back.
    always_comb begin
        rot      = N'({elig, elig} >> start);
        rot_oh   = rot & (~rot + 1'b1);
        pick_oh  = N'(({rot_oh, rot_oh} << start) >> N);
        pick_idx = IW'(oh2idx(OH_MAX'(pick_oh)));
        any      = |elig;
    end

endmodule

// File: rtl/rr_dispatcher.sv
// Credit-based round-robin 1-to-NUM_DST dispatcher (overflow check: RR_DISPATCHER_OVF_CHK_EN).
// Latency: accept in cycle t -> registered one-hot out_valid in t+1.
// Backpressure: in_ready = any credit left; destinations never stall a delivered beat.
module rr_dispatcher
    import rr_dispatch_pkg::*;
#(
    parameter int NUM_DST = DEF_NUM_DST,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CREDITS = DEF_CREDITS
) (
    input  logic           clk,
    input  logic           rst,
    rr_dispatcher_if.master bus
);
    localparam int IDX_W = $clog2(NUM_DST);
    localparam int CW    = cnt_w(CREDITS);
    localparam logic [CW-1:0]    FULL     = CW'(CREDITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DST - 1);

    logic [CW-1:0]      credit [NUM_DST];
    logic [IDX_W-1:0]   last_dst;
    logic [IDX_W-1:0]   start;
    logic [NUM_DST-1:0] avail;
    logic [NUM_DST-1:0] pick_oh;
    logic [NUM_DST-1:0] dec;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               accept;

    logic [NUM_DST-1:0] out_valid_q;
    logic [IDX_W-1:0]   out_dst_q;
    logic [DATA_W-1:0]  out_data_q;

    always_comb begin
        for (int i = 0; i < NUM_DST; i++) begin
            avail[i] = (credit[i] != '0);
        end
        start  = (last_dst == LAST_IDX) ? '0 : last_dst + 1'b1;
        accept = bus.in_valid && pick_any;
        dec    = accept ? pick_oh : '0;
    end

    rr_pick #(.N(NUM_DST)) u_pick (
        .elig     (avail),
        .start    (start),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= '0;
            out_dst_q   <= '0;
            out_data_q  <= '0;
            last_dst    <= LAST_IDX;
            for (int i = 0; i < NUM_DST; i++) credit[i] <= FULL;
        end else begin
            out_valid_q <= dec;
            if (accept) begin
                out_dst_q  <= pick_idx;
                out_data_q <= bus.in_data;
                last_dst   <= pick_idx;
            end
            // Return and dispatch on the same counter cancel out.
            for (int i = 0; i < NUM_DST; i++) begin
                case ({bus.credit_ret[i], dec[i]})
                    2'b10:   if (credit[i] != FULL) credit[i] <= credit[i] + 1'b1;
                    2'b01:   credit[i] <= credit[i] - 1'b1;
                    default: credit[i] <= credit[i];
                endcase
            end
        end
    end

    assign bus.in_ready     = |avail;
    assign bus.credit_avail = avail;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_dst      = out_dst_q;
    assign bus.out_data     = out_data_q;

`ifdef RR_DISPATCHER_OVF_CHK_EN
    logic [NUM_DST-1:0] ovf;
    logic               err_q;

    always_comb begin
        for (int i = 0; i < NUM_DST; i++) begin
            ovf[i] = bus.credit_ret[i] && !dec[i] && (credit[i] == FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)       err_q <= 1'b0;
        else if (|ovf) err_q <= 1'b1;
    end

    assign bus.credit_err = err_q;

    a_no_ovf: assert property (@(posedge clk) disable iff (rst) !(|ovf))
        else $error("rr_dispatcher: credit returned to a full counter");
`else
    assign bus.credit_err = 1'b0;
`endif

endmodule
